// File: rtl/logic_cell_pkg.sv
// Shared definitions for the logic cell: the function-select type and the
// encodings of the four bitwise functions.
package logic_cell_pkg;

    typedef logic [1:0] lc_sel_t;

    localparam lc_sel_t LC_AND  = 2'b00;  // a & b
    localparam lc_sel_t LC_OR   = 2'b01;  // a | b
    localparam lc_sel_t LC_XOR  = 2'b10;  // a ^ b
    localparam lc_sel_t LC_NOTA = 2'b11;  // ~a, b ignored

endpackage : logic_cell_pkg

// File: rtl/logic_cell_bit.sv
// Single-bit combinational logic cell: selects one of four bitwise functions
// of a and b.
// Ports:
//   a, b : operand bits
//   s    : function select (see logic_cell_pkg encodings)
//   y    : selected function result
module logic_cell_bit
    import logic_cell_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  lc_sel_t s,
    output logic    y
);

    always_comb begin
        y = 1'b0;
        case (s)
            LC_AND:  y = a & b;
            LC_OR:   y = a | b;
            LC_XOR:  y = a ^ b;
            LC_NOTA: y = ~a;
            default: y = 1'b0;
        endcase
    end

endmodule : logic_cell_bit

// File: rtl/logic_cell.sv
// WIDTH-bit bitwise logic unit with a registered result.
// One logic_cell_bit per bit position (no inter-bit interaction), followed by
// a result register, a registered all-zeros flag and a valid strobe.
// Ports:
//   clk   : system clock, rising-edge
//   rst   : asynchronous active-high reset (out=0, zero=1, valid=0)
//   en    : operation enable; result register loads only when high
//   a, b  : WIDTH-bit operands
//   S     : function select (00 AND, 01 OR, 10 XOR, 11 NOT a)
//   out   : registered result
//   valid : high for exactly the cycle after an enabled operation
//   zero  : registered flag, high when out is all zeros
module logic_cell
    import logic_cell_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       S,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             zero
);

    logic [WIDTH-1:0] result_next;
    logic [WIDTH-1:0] out_reg;
    logic             valid_reg;
    logic             zero_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic_cell_bit u_bit (
                .a (a[gi]),
                .b (b[gi]),
                .s (lc_sel_t'(S)),
                .y (result_next[gi])
            );
        end
    endgenerate

    // valid follows en every cycle; out/zero only move on enabled cycles so
    // the last result stays visible while the unit is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg   <= '0;
            zero_reg  <= 1'b1;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= en;
            if (en) begin
                out_reg  <= result_next;
                zero_reg <= ~|result_next;
            end
        end
    end

    assign out   = out_reg;
    assign valid = valid_reg;
    assign zero  = zero_reg;

endmodule : logic_cell

// File: tb/tb_logic_cell.sv
module tb_logic_cell;

    logic       clk;
    logic       rst;

    logic       en1, a1, b1;
    logic [1:0] s1;
    logic       out1, valid1, zero1;

    logic       en8;
    logic [7:0] a8, b8;
    logic [1:0] s8;
    logic [7:0] out8;
    logic       valid8, zero8;

    int vectors;
    int miscompares;

    logic [0:15] tt;

    logic_cell #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .a(a1), .b(b1), .S(s1),
        .out(out1), .valid(valid1), .zero(zero1)
    );

    logic_cell #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .a(a8), .b(b8), .S(s8),
        .out(out8), .valid(valid8), .zero(zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        // Truth table, index {a,b,S}: AND,OR,XOR,NOTA per (a,b) row
        tt = 16'b0001_0111_0110_1100;

        rst = 1'b1;
        en1 = 1'b0; a1 = 1'b0; b1 = 1'b0; s1 = 2'b00;
        en8 = 1'b0; a8 = 8'h00; b8 = 8'h00; s8 = 2'b00;

        // Reset state
        #3;
        check("rst_out1",   {63'd0, out1},   64'd0);
        check("rst_zero1",  {63'd0, zero1},  64'd1);
        check("rst_valid1", {63'd0, valid1}, 64'd0);
        check("rst_out8",   {56'd0, out8},   64'd0);
        check("rst_zero8",  {63'd0, zero8},  64'd1);
        check("rst_valid8", {63'd0, valid8}, 64'd0);

        @(negedge clk);
        rst = 1'b0;

        // Exhaustive single-bit truth table, back-to-back
        en1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a1 = i[3];
            b1 = i[2];
            s1 = i[1:0];
            tick();
            check($sformatf("tt_out[%0d]", i),   {63'd0, out1},   {63'd0, tt[i]});
            check($sformatf("tt_zero[%0d]", i),  {63'd0, zero1},  {63'd0, ~tt[i]});
            check($sformatf("tt_valid[%0d]", i), {63'd0, valid1}, 64'd1);
            $display("tt a=%0b b=%0b S=%0b -> out=%0b zero=%0b valid=%0b", a1, b1, s1, out1, zero1, valid1);
        end
        en1 = 1'b0;

        // Wide vectors
        en8 = 1'b1; a8 = 8'hC5; b8 = 8'h3A;
        s8 = 2'b00; tick();
        check("w_and_out",  {56'd0, out8},  64'h00);
        check("w_and_zero", {63'd0, zero8}, 64'd1);
        check("w_and_valid",{63'd0, valid8},64'd1);
        $display("wide S=00 out=%02h zero=%0b", out8, zero8);
        s8 = 2'b01; tick();
        check("w_or_out",   {56'd0, out8},  64'hFF);
        check("w_or_zero",  {63'd0, zero8}, 64'd0);
        $display("wide S=01 out=%02h zero=%0b", out8, zero8);
        s8 = 2'b10; tick();
        check("w_xor_out",  {56'd0, out8},  64'hFF);
        $display("wide S=10 out=%02h zero=%0b", out8, zero8);
        s8 = 2'b11; tick();
        check("w_nota_out", {56'd0, out8},  64'h3A);
        check("w_nota_zero",{63'd0, zero8}, 64'd0);
        $display("wide S=11 out=%02h zero=%0b", out8, zero8);
        en8 = 1'b0;
        tick();
        check("w_idle_valid", {63'd0, valid8}, 64'd0);
        check("w_idle_out",   {56'd0, out8},   64'h3A);

        // Enable hold
        en1 = 1'b1; a1 = 1'b1; b1 = 1'b1; s1 = 2'b00;
        tick();
        check("hold_load_out",   {63'd0, out1},   64'd1);
        check("hold_load_valid", {63'd0, valid1}, 64'd1);
        $display("hold load out=%0b valid=%0b", out1, valid1);
        en1 = 1'b0; a1 = 1'b0; s1 = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_out[%0d]", i),   {63'd0, out1},   64'd1);
            check($sformatf("hold_valid[%0d]", i), {63'd0, valid1}, 64'd0);
            check($sformatf("hold_zero[%0d]", i),  {63'd0, zero1},  64'd0);
            $display("hold cycle %0d out=%0b valid=%0b", i, out1, valid1);
        end

        // Asynchronous reset between edges
        #1;
        rst = 1'b1;
        #1;
        check("arst_out",   {63'd0, out1},   64'd0);
        check("arst_zero",  {63'd0, zero1},  64'd1);
        check("arst_valid", {63'd0, valid1}, 64'd0);
        $display("async rst out=%0b zero=%0b valid=%0b", out1, zero1, valid1);

        // Operation sampled while rst is high is discarded
        en1 = 1'b1; a1 = 1'b1; b1 = 1'b0; s1 = 2'b01;
        tick();
        check("rst_disc_out",   {63'd0, out1},   64'd0);
        check("rst_disc_valid", {63'd0, valid1}, 64'd0);
        $display("rst discard out=%0b valid=%0b", out1, valid1);

        #1;
        rst = 1'b0;
        a1 = 1'b1; s1 = 2'b11;
        tick();
        check("post_rst_out",   {63'd0, out1},   64'd0);
        check("post_rst_zero",  {63'd0, zero1},  64'd1);
        check("post_rst_valid", {63'd0, valid1}, 64'd1);
        $display("post rst out=%0b zero=%0b valid=%0b", out1, zero1, valid1);

        // Throughput: S changes every cycle
        a1 = 1'b1; b1 = 1'b0;
        s1 = 2'b00; tick();
        check("tp_and", {63'd0, out1}, 64'd0);
        s1 = 2'b01; tick();
        check("tp_or",  {63'd0, out1}, 64'd1);
        s1 = 2'b10; tick();
        check("tp_xor", {63'd0, out1}, 64'd1);
        check("tp_xor_valid", {63'd0, valid1}, 64'd1);
        s1 = 2'b11; tick();
        check("tp_nota", {63'd0, out1}, 64'd0);
        check("tp_nota_zero", {63'd0, zero1}, 64'd1);
        $display("throughput final out=%0b zero=%0b", out1, zero1);
        en1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_logic_cell

// File: doc/logic_cell.md
Name: logic_cell

Overview:
- Bitwise logic cell / logic unit slice of the entrega-1 logic unit.
- Selects one of four bitwise functions of operands a and b via the 2-bit selector S.
- Result is registered: one clock of latency, with a valid strobe and a zero flag for the surrounding ALU/flag logic.
- WIDTH=1 is the single-bit cell; wider instances form the N-bit logic unit.

Parameters:
- WIDTH, 1, operand/result width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  operation enable; the result register loads only when en=1.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- S  input  2  function select.
- out  output  WIDTH  registered result.
- valid  output  1  high for exactly the cycle after an enabled operation.
- zero  output  1  registered flag, 1 when out is all zeros.

Behaviour:
- Function encoding, applied bitwise, per bit i:
  - S=00: out[i] = a[i] AND b[i]
  - S=01: out[i] = a[i] OR b[i]
  - S=10: out[i] = a[i] XOR b[i]
  - S=11: out[i] = NOT a[i]; b is ignored.
- Combinational result f(a,b,S) is computed every cycle. There is no carry or interaction between bits.
- Rising clk with en=1: out <= f(a,b,S); zero <= (f(a,b,S) == 0); valid <= 1.
- Rising clk with en=0: out and zero hold their values; valid <= 0.
- Latency is exactly 1 cycle from the sampled inputs to out/zero/valid. Back-to-back operations with en held high give one result per cycle.
- rst asserted, at any time and independent of clk: out=0, zero=1, valid=0 immediately. These values persist while rst=1.
- Reset mid-operation: any operation sampled in the same cycle that rst is high is discarded.
- First operation after rst deasserts: on the first rising edge with rst=0 and en=1.
- S or operands changing while en=0 have no visible effect.
- X/Z on S while en=1 is not defined behaviour and is not supported; the bench never drives it.
- No handshake or backpressure: the consumer must take out whenever valid=1.

Decomposition:
- Shared package logic_cell_pkg:
  - 2-bit select constants LC_AND=2'b00, LC_OR=2'b01, LC_XOR=2'b10, LC_NOTA=2'b11.
  - typedef lc_sel_t for S.
- One natural sub-module, logic_cell_bit: purely combinational single-bit 4-function mux (y from a, b, S).
  - Instantiated WIDTH times via generate.
  - The top adds the result register, zero reduction and valid register.

Test Plan:
- Exhaustive single-bit truth table, WIDTH=1, en=1, all 16 (a,b,S) combinations in order a,b,S ascending. Required out, one cycle later:
  - a=0,b=0 -> 0,0,0,1
  - a=0,b=1 -> 0,1,1,1
  - a=1,b=0 -> 0,1,1,0
  - a=1,b=1 -> 1,1,0,0
  - valid=1 throughout.
- Wide vectors, WIDTH=8, a=8'hC5, b=8'h3A, S=00/01/10/11 -> out=8'h00 (zero=1), 8'hFF, 8'hFF, 8'h3A (zero=0).
- Enable hold:
  - Load a=1,b=1,S=00 (out=1).
  - Then en=0 with a=0,S=11 for 3 cycles -> out stays 1, valid=0 on those cycles.
- Asynchronous reset: assert rst between clock edges while out=1 -> out=0, zero=1, valid=0 before the next edge. Deassert rst, en=1, a=1,S=11 -> next cycle out=0, zero=1, valid=1.
- Throughput: en high, change S every cycle 00->01->10->11 with a=1,b=0 -> out sequence 0,1,1,0 on consecutive cycles, each one cycle after its input.
